// File: rtl/lsu_mem_ctrl_if.sv
// Memory-side req/ack port of the load/store unit.
// Signal suffixes are from the LSU's point of view.
interface lsu_mem_ctrl_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit: one aligned req/ack access per M-stage op, pipeline stall, load extension.
// Optional LSU_TIMEOUT_EN builds the REQ timeout counter that drives bus_err_o.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_M,
  input  logic         rd_en,
  input  logic         wr_en,
  input  logic [2:0]   funct3,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic         stall_o,
  output logic [31:0]  rdata_o,
  output logic         rdata_valid_o,
  output logic         access_fault_o,
  output logic         bus_err_o,
  lsu_mem_ctrl_if.master mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        bus_err_q, bus_err_d;

  logic        legal_f3, misalign, one_op, accept, timeout_hit;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request decode and fault detection on the live M-stage inputs
  always_comb begin
    legal_f3 = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
    one_op   = rd_en ^ wr_en;
    accept   = (state_q == IDLE) && valid_M && one_op && legal_f3 && !misalign;
    access_fault_o = rst && (state_q == IDLE) && valid_M &&
                     ((rd_en && wr_en) || (one_op && (!legal_f3 || misalign)));
    // Gated by reset so every output reads 0 while rst is low
    stall_o  = rst && (accept || (state_q == REQ));
  end

  // Byte-lane placement for stores
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {addr[1], 1'b0};
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Load lane select and extension from the registered offset/funct3
  always_comb begin
    case (off_q)
      2'b00:   ld_byte = mem.mem_rdata_i[7:0];
      2'b01:   ld_byte = mem.mem_rdata_i[15:8];
      2'b10:   ld_byte = mem.mem_rdata_i[23:16];
      default: ld_byte = mem.mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
    case (f3_q[1:0])
      2'b00:   load_ext = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: load_ext = mem.mem_rdata_i;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = (state_q == REQ) ? cnt_q + 8'd1 : 8'd0;
    timeout_hit = (state_q == REQ) && (cnt_q == 8'(MEM_TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(MEM_TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // Next-state and registered output logic
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    f3_d          = f3_q;
    off_d         = off_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    bus_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = wr_en;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = wdata_c;
          mem_be_d    = be_c;
          f3_d        = funct3;
          off_d       = addr[1:0];
        end
      end
      REQ: begin
        if (mem.mem_ack_i) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d       = load_ext;
            rdata_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = 32'd0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      mem_be_q      <= 4'd0;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign mem.mem_req_o   = mem_req_q;
  assign mem.mem_we_o    = mem_we_q;
  assign mem.mem_addr_o  = mem_addr_q;
  assign mem.mem_wdata_o = mem_wdata_q;
  assign mem.mem_be_o    = mem_be_q;
  assign rdata_o         = rdata_q;
  assign rdata_valid_o   = rdata_valid_q;
  assign bus_err_o       = bus_err_q;

endmodule
